// File: rtl/ecg_pkg.sv
// Shared ECG front-end definitions: patch geometry, the patch array type and
// the bank state encoding used by the patch buffer and the linear embedding.
package ecg_pkg;

  localparam int PATCH_LEN = 15;
  localparam int SAMPLE_W  = 8;
  localparam int SEQ_W     = 8;
  localparam int DROP_W    = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef sample_t patch_t [0:PATCH_LEN-1];

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

endpackage

// File: rtl/ecg_patch_buffer_if.sv
// Sample stream in, patch presentation out, plus the drop counter; the slave
// view belongs to the patch buffer, the master view to its environment.
interface ecg_patch_buffer_if #(
  parameter int PATCH_LEN = ecg_pkg::PATCH_LEN,
  parameter int SAMPLE_W  = ecg_pkg::SAMPLE_W
);
  import ecg_pkg::*;

  logic                       s_valid;
  logic signed [SAMPLE_W-1:0] s_data;
  logic                       s_ready;
  logic signed [SAMPLE_W-1:0] patch_out [0:PATCH_LEN-1];
  logic                       patch_valid;
  logic                       patch_ack;
  logic [SEQ_W-1:0]           patch_seq;
  logic [DROP_W-1:0]          drop_cnt;

  modport master (
    output s_valid, s_data, patch_ack,
    input  s_ready, patch_out, patch_valid, patch_seq, drop_cnt
  );

  modport slave (
    input  s_valid, s_data, patch_ack,
    output s_ready, patch_out, patch_valid, patch_seq, drop_cnt
  );

endinterface

// File: rtl/ecg_patch_bank.sv
// One patch worth of sample storage, written one sample at a time by index.
// Holds data only, so it carries no reset.
module ecg_patch_bank #(
  parameter  int PATCH_LEN = ecg_pkg::PATCH_LEN,
  parameter  int SAMPLE_W  = ecg_pkg::SAMPLE_W,
  localparam int IDX_W     = (PATCH_LEN > 1) ? $clog2(PATCH_LEN) : 1
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [IDX_W-1:0]           idx,
  input  logic signed [SAMPLE_W-1:0] din,
  output logic signed [SAMPLE_W-1:0] data [0:PATCH_LEN-1]
);

  always_ff @(posedge clk) begin
    if (we) begin
      data[idx] <= din;
    end
  end

endmodule

// File: rtl/ecg_patch_buffer.sv
// Ping-pong patch buffer: gathers PATCH_LEN samples per bank and presents
// completed patches in arrival order until the consumer acknowledges them.
module ecg_patch_buffer #(
  parameter int PATCH_LEN = ecg_pkg::PATCH_LEN,
  parameter int SAMPLE_W  = ecg_pkg::SAMPLE_W
) (
  input logic               clk,
  input logic               rst,
  ecg_patch_buffer_if.slave bus
);
  import ecg_pkg::*;

  localparam int               IDX_W    = (PATCH_LEN > 1) ? $clog2(PATCH_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATCH_LEN - 1);

  bank_state_t                bank_st   [2];
  bank_state_t                bank_st_n [2];
  logic                       fill_sel, fill_sel_n;
  logic                       pres_sel, pres_sel_n;
  logic [IDX_W-1:0]           fill_idx, fill_idx_n;
  logic [SEQ_W-1:0]           seq, seq_n;
  logic [DROP_W-1:0]          drop, drop_n;

  logic                       ready, valid, accept, complete, ack, no_filling;
  logic                       we0, we1;
  logic signed [SAMPLE_W-1:0] bank0_q [0:PATCH_LEN-1];
  logic signed [SAMPLE_W-1:0] bank1_q [0:PATCH_LEN-1];

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Everything below the flops depends only on registered bank state, so
  // s_ready never sees patch_ack or s_valid combinationally.
  assign ready      = !(bank_st[0] == BANK_FULL && bank_st[1] == BANK_FULL);
  assign no_filling = (bank_st[0] != BANK_FILLING) && (bank_st[1] != BANK_FILLING);
  assign valid      = (bank_st[pres_sel] == BANK_FULL);
  assign accept     = bus.s_valid & ready;
  assign complete   = accept & (fill_idx == LAST_IDX);
  assign ack        = bus.patch_ack & valid;
  assign we0        = accept & ~fill_sel;
  assign we1        = accept & fill_sel;

  ecg_patch_bank #(.PATCH_LEN(PATCH_LEN), .SAMPLE_W(SAMPLE_W)) u_bank0 (
    .clk  (clk),
    .we   (we0),
    .idx  (fill_idx),
    .din  (bus.s_data),
    .data (bank0_q)
  );

  ecg_patch_bank #(.PATCH_LEN(PATCH_LEN), .SAMPLE_W(SAMPLE_W)) u_bank1 (
    .clk  (clk),
    .we   (we1),
    .idx  (fill_idx),
    .din  (bus.s_data),
    .data (bank1_q)
  );

  // Release is applied before completion so that a bank freed at the same
  // edge can immediately take over filling.
  always_comb begin
    bank_st_n[0] = bank_st[0];
    bank_st_n[1] = bank_st[1];
    fill_sel_n   = fill_sel;
    pres_sel_n   = pres_sel;
    fill_idx_n   = fill_idx;
    seq_n        = seq;
    drop_n       = drop;

    if (ack) begin
      bank_st_n[pres_sel] = no_filling ? BANK_FILLING : BANK_EMPTY;
      pres_sel_n          = ~pres_sel;
      seq_n               = seq + 1'b1;
    end

    if (accept) begin
      if (complete) begin
        fill_idx_n          = '0;
        bank_st_n[fill_sel] = BANK_FULL;
        if (bank_st_n[~fill_sel] == BANK_EMPTY) begin
          bank_st_n[~fill_sel] = BANK_FILLING;
        end
        fill_sel_n = ~fill_sel;
      end else begin
        fill_idx_n = fill_idx + 1'b1;
      end
    end

    if (bus.s_valid && !ready) begin
      drop_n = sat_inc(drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= BANK_FILLING;
      bank_st[1] <= BANK_EMPTY;
      fill_sel   <= 1'b0;
      pres_sel   <= 1'b0;
      fill_idx   <= '0;
      seq        <= '0;
      drop       <= '0;
    end else begin
      bank_st[0] <= bank_st_n[0];
      bank_st[1] <= bank_st_n[1];
      fill_sel   <= fill_sel_n;
      pres_sel   <= pres_sel_n;
      fill_idx   <= fill_idx_n;
      seq        <= seq_n;
      drop       <= drop_n;
    end
  end

  assign bus.s_ready     = ready;
  assign bus.patch_valid = valid;
  assign bus.patch_seq   = seq;
  assign bus.drop_cnt    = drop;

  // Zero when nothing is presented, which also covers the post-reset value.
  always_comb begin
    for (int i = 0; i < PATCH_LEN; i++) begin
      bus.patch_out[i] = '0;
      if (valid) begin
        bus.patch_out[i] = pres_sel ? bank1_q[i] : bank0_q[i];
      end
    end
  end

endmodule

// File: tb/tb_ecg_patch_buffer.sv
// Bench for ecg_patch_buffer: a queue-based reference model of the buffer
// feeds a scoreboard that a separate monitor drains at each new presentation.
module tb_ecg_patch_buffer;

  localparam int PL = ecg_pkg::PATCH_LEN;
  localparam int SW = ecg_pkg::SAMPLE_W;

  typedef struct packed {
    logic [7:0]         seq;
    logic [PL*SW-1:0]   data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ecg_patch_buffer_if #(.PATCH_LEN(PL), .SAMPLE_W(SW)) bif ();

  ecg_patch_buffer #(.PATCH_LEN(PL), .SAMPLE_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: completed-but-unconsumed patches, the partial patch,
  // a count of completed patches and the drop counter.
  exp_t mfull[$];
  exp_t sb_q[$];
  int   partial[$];
  int   seq_ctr = 0;
  int   mdrop   = 0;

  exp_t cur;
  logic prev_valid = 1'b0;
  logic pend_ack   = 1'b0;
  logic mon_en     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mfull.delete();
    sb_q.delete();
    partial.delete();
    seq_ctr = 0;
    mdrop   = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit a);
    bit   rdy;
    exp_t e;
    rdy = (mfull.size() < 2);
    if (a && mfull.size() > 0) void'(mfull.pop_front());
    if (v && rdy) begin
      partial.push_back(d);
      if (partial.size() == PL) begin
        e.seq = seq_ctr[7:0];
        for (int i = 0; i < PL; i++) e.data[i*SW +: SW] = SW'(partial[i]);
        mfull.push_back(e);
        sb_q.push_back(e);
        partial.delete();
        seq_ctr++;
      end
    end else if (v) begin
      if (mdrop < 65535) mdrop++;
    end
  endtask

  task automatic step(input bit v, input int d, input bit a);
    bif.s_valid   = v;
    bif.s_data    = SW'(d);
    bif.patch_ack = a;
    @(posedge clk);
    #1;
    model_step(v, d, a);
  endtask

  task automatic do_reset();
    bif.s_valid   = 1'b0;
    bif.s_data    = '0;
    bif.patch_ack = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
  endtask

  // Monitor: per-cycle status against the model, and patch contents against
  // the scoreboard entry popped when a new patch is presented.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("s_ready", 32'(bif.s_ready), 32'(mfull.size() < 2));
      check("patch_valid", 32'(bif.patch_valid), 32'(mfull.size() > 0));
      check("drop_cnt", 32'(bif.drop_cnt), 32'(mdrop));
      if (bif.patch_valid === 1'b1) begin
        if (!prev_valid || pend_ack) begin
          if (sb_q.size() == 0) begin
            check("sb_nonempty", 32'(sb_q.size()), 32'd1);
          end else begin
            cur = sb_q.pop_front();
          end
        end
        begin
          int bad;
          bad = -1;
          for (int i = PL - 1; i >= 0; i--)
            if (bif.patch_out[i] !== cur.data[i*SW +: SW]) bad = i;
          if (bad < 0) check("patch_out", 32'd0, 32'd0 + 32'(bad + 1));
          else check($sformatf("patch_out[%0d]", bad), 32'(unsigned'(bif.patch_out[bad])),
                     32'(cur.data[bad*SW +: SW]));
        end
        check("patch_seq", 32'(bif.patch_seq), 32'(cur.seq));
      end
    end
    prev_valid = (bif.patch_valid === 1'b1);
    pend_ack   = (bif.patch_ack === 1'b1) && (bif.patch_valid === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bif.s_valid   = 1'b0;
    bif.s_data    = '0;
    bif.patch_ack = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset values
    check("rst_s_ready", 32'(bif.s_ready), 32'd1);
    check("rst_patch_valid", 32'(bif.patch_valid), 32'd0);
    check("rst_patch_seq", 32'(bif.patch_seq), 32'd0);
    check("rst_drop_cnt", 32'(bif.drop_cnt), 32'd0);
    for (int i = 0; i < PL; i++) check("rst_patch_out", 32'(bif.patch_out[i]), 32'd0);

    // First patch, latency of one cycle after the last sample
    for (int k = 1; k <= 15; k++) step(1'b1, k, 1'b0);
    check("first_valid", 32'(bif.patch_valid), 32'd1);
    check("first_out0", 32'(bif.patch_out[0]), 32'd1);
    check("first_out14", 32'(bif.patch_out[14]), 32'd15);
    check("first_seq", 32'(bif.patch_seq), 32'd0);

    // Overflow without consumer
    for (int k = 16; k <= 45; k++) step(1'b1, k, 1'b0);
    step(1'b0, 0, 1'b0);
    check("ovf_drop_cnt", 32'(bif.drop_cnt), 32'd15);
    check("ovf_s_ready", 32'(bif.s_ready), 32'd0);
    check("ovf_out0", 32'(bif.patch_out[0]), 32'd1);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b0);
    end
    check("ovf_drained", 32'(bif.patch_valid), 32'd0);

    // Streaming with a prompt consumer
    do_reset();
    for (int k = 1; k <= 30; k++) step(1'b1, k, mfull.size() > 0);
    for (int k = 0; k < 3; k++) step(1'b0, 0, mfull.size() > 0);
    check("stream_drop_cnt", 32'(bif.drop_cnt), 32'd0);
    check("stream_seq", 32'(bif.patch_seq), 32'd2);

    // Ack coinciding with the completing sample
    do_reset();
    for (int k = 1; k <= 29; k++) step(1'b1, k, 1'b0);
    step(1'b1, 30, 1'b1);
    check("coinc_valid", 32'(bif.patch_valid), 32'd1);
    check("coinc_out0", 32'(bif.patch_out[0]), 32'd16);
    check("coinc_out14", 32'(bif.patch_out[14]), 32'd30);
    check("coinc_s_ready", 32'(bif.s_ready), 32'd1);
    check("coinc_seq", 32'(bif.patch_seq), 32'd1);
    step(1'b0, 0, 1'b1);

    // Reset mid-fill, then a fresh patch
    do_reset();
    for (int k = 1; k <= 7; k++) step(1'b1, k, 1'b0);
    do_reset();
    for (int k = 100; k <= 114; k++) step(1'b1, k, 1'b0);
    check("midrst_out0", 32'(bif.patch_out[0]), 32'd100);
    check("midrst_seq", 32'(bif.patch_seq), 32'd0);

    // Reset mid-presentation with reset and ack asserted together
    for (int k = 0; k < 5; k++) step(1'b1, 200 + k, 1'b0);
    bif.patch_ack = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bif.patch_ack = 1'b0;
    model_reset();
    check("presrst_valid", 32'(bif.patch_valid), 32'd0);
    check("presrst_seq", 32'(bif.patch_seq), 32'd0);

    // Idle acks, then 300 random patches through a random consumer
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 0, 1'b1);
    check("idle_ack_seq", 32'(bif.patch_seq), 32'd0);
    guard = 0;
    while (seq_ctr < 300 && guard < 20000) begin
      step($urandom_range(0, 4) != 0, int'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
      guard++;
    end
    check("stream300_budget", 32'(guard < 20000), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b0);
    end
    check("stream300_seq", 32'(bif.patch_seq), 32'(seq_ctr % 256));

    // Slow consumer: stalls and drops under random traffic
    for (int k = 0; k < 2000; k++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)), $urandom_range(0, 15) == 0);
    step(1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecg_patch_buffer.md
ECG_PATCH_BUFFER -- requirements
Module: ecg_patch_buffer

Interface
REQ-001 Parameter PATCH_LEN, default 15: samples per patch, equal to the downstream linear_embedding input width.
REQ-002 Parameter SAMPLE_W, default 8: signed sample width in bits.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_valid  input  1  upstream sample valid.
REQ-006 s_data  input  SAMPLE_W signed  ECG sample, valid when s_valid=1.
REQ-007 s_ready  output  1  buffer accepts a sample this cycle.
REQ-008 patch_out  output  [0:PATCH_LEN-1] x SAMPLE_W signed  oldest complete patch; element 0 = first-received sample.
REQ-009 patch_valid  output  1  patch_out holds a complete, unconsumed patch.
REQ-010 patch_ack  input  1  one-cycle pulse from the consumer (its done) that releases the presented patch.
REQ-011 patch_seq  output  8  sequence number of the presented patch; wraps 255->0.
REQ-012 drop_cnt  output  16  saturating count of cycles with s_valid=1 and s_ready=0.

Function
REQ-013 Two patch banks (ping-pong) SHALL exist, each with state EMPTY, FILLING or FULL.
REQ-014 A sample SHALL be accepted at a rising edge when s_valid=1 and s_ready=1, written at the fill index of the FILLING bank, and the index incremented.
REQ-015 s_ready SHALL be a function of registered state only: 1 iff a bank is FILLING or EMPTY; no combinational path from patch_ack or s_valid.
REQ-016 On accepting the sample at index PATCH_LEN-1, the bank SHALL become FULL, the index SHALL return to 0, and the other bank, if EMPTY, SHALL become FILLING at the same edge.
REQ-017 If the other bank is FULL at that edge, no bank SHALL be FILLING and s_ready SHALL be 0 from the next cycle.
REQ-018 patch_valid SHALL rise the cycle after the edge that completes a patch (one-cycle latency from last sample to patch_valid).
REQ-019 While patch_valid=1, patch_out and patch_seq SHALL be held stable until patch_ack.
REQ-020 On patch_ack with patch_valid=1, the presented bank SHALL become EMPTY (or FILLING if no bank is FILLING), and the other bank, if FULL, SHALL be presented from the next cycle with patch_seq+1.
REQ-021 patch_ack while patch_valid=0 SHALL be ignored.
REQ-022 A patch completion and a patch_ack at the same edge SHALL both take effect, and no sample SHALL be lost or duplicated.
REQ-023 Completed patches SHALL be presented strictly in arrival order.
REQ-024 drop_cnt SHALL saturate at 16'hFFFF, and a dropped sample SHALL not alter any bank.

Reset
REQ-025 On rst=1 at a rising edge: bank 0 FILLING, bank 1 EMPTY, fill index 0, s_ready=1, patch_valid=0, patch_seq=0, drop_cnt=0, patch_out all zeros.
REQ-026 Reset mid-fill or mid-presentation SHALL discard all partial and full patches, and rst SHALL take priority over s_valid and patch_ack.

Structure
REQ-027 PATCH_LEN, SAMPLE_W and the patch_t unpacked-array typedef SHALL reside in the shared package ecg_pkg, which is also used by linear_embedding.
REQ-028 One sub-module, ecg_patch_bank (PATCH_LEN x SAMPLE_W register file with write enable and index), SHALL be instantiated twice; the bank FSM and output mux SHALL stay in the top module.

Verification
REQ-029 Reset, then stream samples 1..15 with s_valid held high -> patch_valid=1 the cycle after the 15th sample, patch_out={1..15}, patch_seq=0.
REQ-030 Stream 1..45 with no patch_ack -> s_ready=0 after sample 30, samples 31..45 are counted in drop_cnt=15, and the first patch stays {1..15}.
REQ-031 Stream 1..30 with patch_ack one cycle after each patch_valid rise -> patches {1..15} (seq 0) then {16..30} (seq 1), drop_cnt=0.
REQ-032 patch_ack at the same edge that accepts sample 30 -> next cycle patch_out={16..30}, patch_valid=1, s_ready=1.
REQ-033 rst asserted after 7 samples, then stream 100..114 -> first patch {100..114}, seq 0.
REQ-034 patch_ack pulses while idle, plus 300 patches streamed -> ack ignored while idle, and patch_seq wraps 255->0 with no order error.
